// File: rtl/clkwiz_reconfig_responder_pkg.sv
// Shared register map, state encoding and write helper for the clock-wizard
// reconfiguration handshake. The initiator side reuses the same definitions.
package clkwiz_reconfig_responder_pkg;

    localparam logic [10:0] ADDR_CFG0 = 11'h200;
    localparam logic [10:0] ADDR_CFG2 = 11'h208;
    localparam logic [10:0] ADDR_CTRL = 11'h25C;

    localparam logic [1:0]  CTRL_LOAD = 2'b11;

    // The reset idle state is the same encoding as IDLE; valids are held low
    // by their own register until the first cycle after reset is released.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK  = 2'b01,
        BUSY = 2'b10
    } respStateT;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] byteMaskWrite(
        input logic [31:0] oldVal,
        input logic [31:0] newVal,
        input logic [3:0]  strb
    );
        logic [31:0] result;
        result = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = newVal[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/clkwiz_reconfig_responder_lock_timer.sv
// Relock interval down-counter: loaded on commit, counts down while enabled,
// flags done at terminal count zero and holds there.
module clkwiz_reconfig_responder_lock_timer #(
    parameter int WIDTH = 7
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             loadEn,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             countEn,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load takes priority; counting stops at zero so the value can never wrap.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            count <= '0;
        end else if (loadEn) begin
            count <= loadValue;
        end else if (countEn && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/clkwiz_reconfig_responder.sv
// Responder side of the frequency-update register-write handshake. Holds
// shadow CFG registers, commits them to the active outputs on a LOAD write to
// CTRL, then drops locked_out for the relock interval.
//
//  state | meaning
//  IDLE  | valids high, waiting for both readies to capture a write
//  ACK   | write captured, valids low, waiting for both readies to drop
//  BUSY  | shadows committed, relock timer running, locked_out low
module clkwiz_reconfig_responder
    import clkwiz_reconfig_responder_pkg::*;
#(
    parameter int          LOCK_CYCLES = 64,
    parameter logic [31:0] CFG0_RST    = 32'h0000_0A01,
    parameter logic [31:0] CFG2_RST    = 32'h0000_000A
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [31:0] FreqData_in,
    input  logic [10:0] FreqAddr_in,
    input  logic [3:0]  strbEnable_in,
    input  logic        DataReady_in,
    input  logic        AddrReady_in,
    output logic        DataValid_out,
    output logic        AddrValid_out,
    output logic [31:0] cfg0_out,
    output logic [31:0] cfg2_out,
    output logic        locked_out,
    output logic        reconfig_pulse,
    output logic        bad_addr_err
);

    localparam int              TIMER_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCK_CYCLES - 1);

    respStateT   state;
    respStateT   nextState;

    logic        validReg;
    logic        lockedReg;
    logic        pulseReg;
    logic        badReg;
    logic [31:0] cfg0Active;
    logic [31:0] cfg2Active;
    logic [31:0] cfg0Shadow;
    logic [31:0] cfg2Shadow;
    // Only the load field of CTRL has any effect, so only that field is held.
    logic [1:0]  ctrlShadow;

    logic        capture;
    logic        released;
    logic        timerDone;
    logic        validNext;
    logic        lockedNext;
    logic        commit;

    // A write is taken only while valids are visibly high and both readies agree.
    assign capture  = (state == IDLE) && validReg && DataReady_in && AddrReady_in;
    assign released = !DataReady_in && !AddrReady_in;

    clkwiz_reconfig_responder_lock_timer #(
        .WIDTH (TIMER_W)
    ) u_lockTimer (
        .sysclk    (sysclk),
        .reset     (reset),
        .loadEn    (commit),
        .loadValue (TIMER_LOAD),
        .countEn   (state == BUSY),
        .done      (timerDone)
    );

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode for the write/acknowledge/relock sequence.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    nextState = ACK;
                end
            end
            ACK: begin
                if (released) begin
                    nextState = (ctrlShadow == CTRL_LOAD) ? BUSY : IDLE;
                end
            end
            BUSY: begin
                if (timerDone) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        validNext  = (nextState == IDLE);
        lockedNext = (nextState != BUSY);
        commit     = (state == ACK) && (nextState == BUSY);
    end

    // Output, shadow and active register updates.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            validReg   <= 1'b0;
            lockedReg  <= 1'b1;
            pulseReg   <= 1'b0;
            badReg     <= 1'b0;
            cfg0Active <= CFG0_RST;
            cfg2Active <= CFG2_RST;
            cfg0Shadow <= CFG0_RST;
            cfg2Shadow <= CFG2_RST;
            ctrlShadow <= '0;
        end else begin
            validReg  <= validNext;
            lockedReg <= lockedNext;
            pulseReg  <= commit;

            if (capture) begin
                case (FreqAddr_in)
                    ADDR_CFG0: cfg0Shadow <= byteMaskWrite(cfg0Shadow, FreqData_in, strbEnable_in);
                    ADDR_CFG2: cfg2Shadow <= byteMaskWrite(cfg2Shadow, FreqData_in, strbEnable_in);
                    ADDR_CTRL: begin
                        if (strbEnable_in[0]) begin
                            ctrlShadow <= FreqData_in[1:0];
                        end
                    end
                    default:   badReg <= 1'b1;
                endcase
            end

            // LOAD self-clears so the next acknowledge does not retrigger a commit.
            if (commit) begin
                cfg0Active <= cfg0Shadow;
                cfg2Active <= cfg2Shadow;
                ctrlShadow <= '0;
            end
        end
    end

    assign DataValid_out  = validReg;
    assign AddrValid_out  = validReg;
    assign cfg0_out       = cfg0Active;
    assign cfg2_out       = cfg2Active;
    assign locked_out     = lockedReg;
    assign reconfig_pulse = pulseReg;
    assign bad_addr_err   = badReg;

endmodule

// File: tb/tb_clkwiz_reconfig_responder.sv
// Self-checking bench for clkwiz_reconfig_responder: a register model tracks
// shadow/active values, expected commits are queued when a LOAD is written and
// popped when the responder pulses reconfig_pulse.
module tb_clkwiz_reconfig_responder;

    localparam int          LOCK = 64;
    localparam logic [31:0] C0R  = 32'h0000_0A01;
    localparam logic [31:0] C2R  = 32'h0000_000A;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] FreqData_in   = '0;
    logic [10:0] FreqAddr_in   = '0;
    logic [3:0]  strbEnable_in = '0;
    logic        DataReady_in  = 1'b0;
    logic        AddrReady_in  = 1'b0;
    logic        DataValid_out;
    logic        AddrValid_out;
    logic [31:0] cfg0_out;
    logic [31:0] cfg2_out;
    logic        locked_out;
    logic        reconfig_pulse;
    logic        bad_addr_err;

    clkwiz_reconfig_responder #(
        .LOCK_CYCLES (LOCK),
        .CFG0_RST    (C0R),
        .CFG2_RST    (C2R)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .FreqData_in    (FreqData_in),
        .FreqAddr_in    (FreqAddr_in),
        .strbEnable_in  (strbEnable_in),
        .DataReady_in   (DataReady_in),
        .AddrReady_in   (AddrReady_in),
        .DataValid_out  (DataValid_out),
        .AddrValid_out  (AddrValid_out),
        .cfg0_out       (cfg0_out),
        .cfg2_out       (cfg2_out),
        .locked_out     (locked_out),
        .reconfig_pulse (reconfig_pulse),
        .bad_addr_err   (bad_addr_err)
    );

    always #5 sysclk = ~sysclk;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [63:0] sbQ[$];
    logic [31:0] cfg0M = C0R, cfg2M = C2R, act0M = C0R, act2M = C2R;
    logic [1:0]  ctrlM = 2'b00;
    logic        badM  = 1'b0;
    int          lowCnt = 0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (d & m) | (o & ~m);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic modelReset();
        cfg0M = C0R; cfg2M = C2R; act0M = C0R; act2M = C2R;
        ctrlM = 2'b00; badM = 1'b0;
    endtask

    // Model the effect of one captured write; a LOAD queues the expected commit.
    task automatic applyModelWrite(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] c;
        case (a)
            11'h200: cfg0M = mergeBytes(cfg0M, d, s);
            11'h208: cfg2M = mergeBytes(cfg2M, d, s);
            11'h25C: begin
                c = mergeBytes({30'b0, ctrlM}, d, s);
                ctrlM = c[1:0];
            end
            default: badM = 1'b1;
        endcase
        if (ctrlM == 2'b11) begin
            sbQ.push_back({cfg0M, cfg2M});
            act0M = cfg0M;
            act2M = cfg2M;
            ctrlM = 2'b00;
        end
    endtask

    task automatic waitValids();
        int guard = 0;
        while (!(DataValid_out && AddrValid_out) && guard < 200) begin
            tick(1);
            guard++;
        end
        checkValue("valids_ready", {DataValid_out, AddrValid_out}, 2'b11);
    endtask

    task automatic writeReg(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
        waitValids();
        FreqAddr_in   = a;
        FreqData_in   = d;
        strbEnable_in = s;
        DataReady_in  = 1'b1;
        AddrReady_in  = 1'b1;
        tick(1);
        checkValue("ack_valids", {DataValid_out, AddrValid_out}, 2'b00);
        applyModelWrite(a, d, s);
        DataReady_in = 1'b0;
        AddrReady_in = 1'b0;
        tick(1);
    endtask

    task automatic checkOutputs(input string tag);
        checkValue({tag, "_cfg0"}, cfg0_out, act0M);
        checkValue({tag, "_cfg2"}, cfg2_out, act2M);
        checkValue({tag, "_bad"}, bad_addr_err, badM);
    endtask

    // Commit scoreboard: each pulse must match the oldest queued LOAD.
    always @(negedge sysclk) begin
        logic [63:0] exp;
        if (!reset && reconfig_pulse) begin
            if (sbQ.size() == 0) begin
                checkValue("unexpected_pulse", reconfig_pulse, 1'b0);
            end else begin
                exp = sbQ.pop_front();
                checkValue("commit_cfg0", cfg0_out, exp[63:32]);
                checkValue("commit_cfg2", cfg2_out, exp[31:0]);
            end
        end
    end

    // Relock length: every complete low run of locked_out must last LOCK cycles.
    always @(negedge sysclk) begin
        if (reset) begin
            lowCnt = 0;
        end else if (!locked_out) begin
            lowCnt++;
        end else if (lowCnt != 0) begin
            checkValue("lock_len", lowCnt, LOCK);
            lowCnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles, then released.
        tick(3);
        checkValue("rst_valids", {DataValid_out, AddrValid_out}, 2'b00);
        checkValue("rst_locked", locked_out, 1'b1);
        checkValue("rst_pulse", reconfig_pulse, 1'b0);
        reset = 1'b0;
        tick(1);
        checkValue("post_rst_valids", {DataValid_out, AddrValid_out}, 2'b11);
        checkValue("post_rst_locked", locked_out, 1'b1);
        checkValue("post_rst_cfg0", cfg0_out, 32'h0000_0A01);
        checkValue("post_rst_cfg2", cfg2_out, 32'h0000_000A);

        // Full update sequence followed by LOAD.
        writeReg(11'h200, 32'h0000_0A05, 4'hF);
        writeReg(11'h208, 32'h0000_0014, 4'hF);
        checkOutputs("no_load");
        checkValue("no_load_cfg0_const", cfg0_out, 32'h0000_0A01);
        writeReg(11'h25C, 32'h0000_0003, 4'hF);
        checkValue("load_pulse", reconfig_pulse, 1'b1);
        checkValue("load_locked", locked_out, 1'b0);
        checkValue("load_cfg0", cfg0_out, 32'h0000_0A05);
        checkValue("load_cfg2", cfg2_out, 32'h0000_0014);
        checkValue("busy_valids", {DataValid_out, AddrValid_out}, 2'b00);
        tick(1);
        checkValue("pulse_one_cycle", reconfig_pulse, 1'b0);
        waitValids();
        checkValue("relocked", locked_out, 1'b1);

        // Single-byte strobe into CFG2.
        writeReg(11'h208, 32'hFFFF_FFFF, 4'b0001);
        checkOutputs("strb_preload");
        writeReg(11'h25C, 32'h0000_0003, 4'hF);
        waitValids();
        checkValue("strb_cfg2", cfg2_out, 32'h0000_00FF);
        checkOutputs("strb_load");

        // Unmapped address, then non-LOAD CTRL values, then LOAD.
        writeReg(11'h204, 32'h0000_1234, 4'hF);
        checkValue("bad_addr", bad_addr_err, 1'b1);
        checkOutputs("bad_addr");
        writeReg(11'h25C, 32'h0000_0001, 4'hF);
        writeReg(11'h25C, 32'h0000_0002, 4'hF);
        tick(2);
        checkValue("ctrl_nolock", locked_out, 1'b1);
        writeReg(11'h25C, 32'h0000_0003, 4'h1);
        waitValids();
        checkOutputs("bad_then_load");

        // Only one ready high: no capture until both are high together.
        FreqAddr_in   = 11'h200;
        FreqData_in   = 32'h0000_0B07;
        strbEnable_in = 4'hF;
        AddrReady_in  = 1'b1;
        DataReady_in  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkValue("half_ready_valids", {DataValid_out, AddrValid_out}, 2'b11);
        end
        DataReady_in = 1'b1;
        tick(1);
        checkValue("both_ready_capture", {DataValid_out, AddrValid_out}, 2'b00);
        applyModelWrite(11'h200, 32'h0000_0B07, 4'hF);
        DataReady_in = 1'b0;
        AddrReady_in = 1'b0;
        tick(1);
        checkOutputs("half_ready");
        writeReg(11'h25C, 32'h0000_0003, 4'hF);
        waitValids();
        checkValue("half_ready_cfg0", cfg0_out, 32'h0000_0B07);

        // Reset during BUSY aborts the relock and restores reset values.
        writeReg(11'h208, 32'h0000_0033, 4'hF);
        writeReg(11'h25C, 32'h0000_0003, 4'hF);
        tick(10);
        checkValue("busy_locked", locked_out, 1'b0);
        reset = 1'b1;
        tick(1);
        modelReset();
        checkValue("abort_locked", locked_out, 1'b1);
        checkValue("abort_pulse", reconfig_pulse, 1'b0);
        checkValue("abort_cfg0", cfg0_out, 32'h0000_0A01);
        checkValue("abort_cfg2", cfg2_out, 32'h0000_000A);
        checkOutputs("abort");
        tick(1);
        reset = 1'b0;
        tick(1);
        checkValue("abort_release_valids", {DataValid_out, AddrValid_out}, 2'b11);

        // Shadows were restored too: a bare LOAD commits reset values.
        writeReg(11'h25C, 32'h0000_0003, 4'hF);
        waitValids();
        checkOutputs("post_abort_load");

        checkValue("sb_empty", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
